max_unpool_expand: RTL and testbench

Decoder-side counterpart to the 2:1 max-pool comparator stage. It reads pooled half-precision values and their 1-bit argmax indices from the pooling output BRAM, then rebuilds the 2-lane word in the same 32-bit `conv_concat` packing the pooling stage consumes. The selected value goes back into its original lane and the other lane is zero-filled. Output uses a valid/ready stream with an internal FIFO and credit-limited BRAM reads, so it can feed the SegNet decoder convolution path at one word per clock.

---
 rtl/max_unpool_expand.sv | 226 ++++++++++++++++++++++
 tb/tb_max_unpool_expand.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/max_unpool_expand.sv
// max_unpool_expand
//
// Decoder-side inverse of the 2:1 max-pool comparator. It streams pooled fp16 values and their
// 1-bit argmax indices out of the pooling BRAM. Each value is put back into the lane it was taken
// from, and the other lane of the 32-bit pair is zero-filled. The lane packing matches the
// conv_concat word that the pooling stage consumes. Output words go through a small FIFO onto a
// valid/ready stream. BRAM reads are credit-limited, so the FIFO can never overflow.
//
// Parameters
//   DATA_W        lane width (fp16 bit pattern, never interpreted)
//   ADDR_W        pooled-BRAM address width
//   BRAM_LATENCY  edges from the address-sampling edge to the data-valid edge (1..4)
//   FIFO_DEPTH    output FIFO entries, power of two, >= BRAM_LATENCY + 2
//
// Ports
//   clk, rst           rising-edge clock, synchronous active-high reset
//   start, count       one-cycle job launch and entry count N (sampled together, ignored when busy)
//   Pool_BRAM_en/addr  read request to the pooled BRAM, addresses 0..N-1 in order
//   Pool_read_data     pooled max value returned by the BRAM
//   Pool_read_index    argmax lane: 0 = low lane, 1 = high lane
//   unpool_concat      reconstructed two-lane word (FIFO head, zero when empty)
//   unpool_valid       FIFO non-empty
//   unpool_ready       downstream accepts; a word transfers on valid & ready
//   busy               job in progress
//   done               one-cycle pulse in the cycle after the N-th transfer

module max_unpool_expand #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned BRAM_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W:0]     count,
  output logic                Pool_BRAM_en,
  output logic [ADDR_W-1:0]   Pool_BRAM_addr,
  input  logic [DATA_W-1:0]   Pool_read_data,
  input  logic                Pool_read_index,
  output logic [2*DATA_W-1:0] unpool_concat,
  output logic                unpool_valid,
  input  logic                unpool_ready,
  output logic                busy,
  output logic                done
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StFin} state_e;

  state_e              state_q;
  logic [ADDR_W:0]     count_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                busy_q;
  logic                done_q;

  logic [BRAM_LATENCY-1:0] inflight_q, inflight_d;
  logic [CntW-1:0]         inflight;

  logic [2*DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     occ_q, occ_d;

  logic                credit_ok;
  logic                issue;
  logic                last_addr;
  logic                push;
  logic                pop;
  logic [2*DATA_W-1:0] push_word;

  // ------------------------------------------------------------------------------------------
  // Read issue and in-flight tracking
  // ------------------------------------------------------------------------------------------

  // Reads outstanding in the BRAM pipeline. Each one already owns a FIFO slot.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < BRAM_LATENCY; i++) begin
      inflight = inflight + CntW'(inflight_q[i]);
    end
  end

  // The credit check ignores a pop in the same cycle. This keeps the issue decision off the
  // downstream ready path, at the cost of at most one cycle of slack.
  always_comb begin
    credit_ok = ({1'b0, occ_q} + {1'b0, inflight}) < (CntW + 1)'(FIFO_DEPTH);
    issue     = (state_q == StRun) && credit_ok;
    last_addr = ({1'b0, addr_q} == (count_q - (ADDR_W + 1)'(1)));
  end

  always_comb begin
    inflight_d[0] = issue;
    for (int i = 1; i < BRAM_LATENCY; i++) begin
      inflight_d[i] = inflight_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  // ------------------------------------------------------------------------------------------
  // Lane expansion and output FIFO
  // ------------------------------------------------------------------------------------------

  // Clearing inflight_q on reset is what discards BRAM data still returning after a reset.
  assign push = inflight_q[BRAM_LATENCY-1];
  assign pop  = unpool_valid && unpool_ready;

  always_comb begin
    if (Pool_read_index) begin
      push_word = {Pool_read_data, {DATA_W{1'b0}}};
    end else begin
      push_word = {{DATA_W{1'b0}}, Pool_read_data};
    end
  end

  always_comb begin
    occ_d = occ_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      occ_q <= occ_d;
    end
  end

  // Storage has no reset. The visible head is gated by valid, so stale entries never leak out.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= push_word;
    end
  end

  // The credit scheme makes an overflow impossible. This catches a broken invariant.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !pop && (occ_q == CntW'(FIFO_DEPTH))));
    end
  end

  // ------------------------------------------------------------------------------------------
  // Job control
  // ------------------------------------------------------------------------------------------

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      count_q <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            count_q <= count;
            addr_q  <= '0;
            busy_q  <= 1'b1;
            // An empty job has nothing to read. It takes one DRAIN cycle, which trivially
            // succeeds, so done lands two edges after start.
            if (count == '0) begin
              state_q <= StDrain;
            end else begin
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          if (issue) begin
            if (last_addr) begin
              // Hold the last address rather than step past all-ones when N = 2^ADDR_W.
              state_q <= StDrain;
            end else begin
              addr_q <= addr_q + ADDR_W'(1);
            end
          end
        end
        StDrain: begin
          // Look ahead through this cycle's pop so done follows the final transfer directly.
          if ((inflight == '0) && (occ_d == '0)) begin
            state_q <= StFin;
            done_q  <= 1'b1;
          end
        end
        StFin: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------------------------------

  assign Pool_BRAM_en   = issue;
  assign Pool_BRAM_addr = addr_q;
  assign unpool_valid   = (occ_q != '0);
  assign unpool_concat  = unpool_valid ? mem_q[rd_ptr_q] : '0;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_max_unpool_expand.sv
// Self-checking bench for max_unpool_expand with the default parameters (DATA_W 16, ADDR_W 10,
// BRAM_LATENCY 2, FIFO_DEPTH 4). A behavioural BRAM supplies the data. A word queue, filled from
// the lane-placement rule, checks every transfer. A passive monitor checks the read addresses,
// the read credit and the hold behaviour under back-pressure.

module tb_max_unpool_expand;

  logic        clk;
  logic        rst;
  logic        start;
  logic [10:0] count;
  logic        Pool_BRAM_en;
  logic [9:0]  Pool_BRAM_addr;
  logic [15:0] Pool_read_data;
  logic        Pool_read_index;
  logic [31:0] unpool_concat;
  logic        unpool_valid;
  logic        unpool_ready;
  logic        busy;
  logic        done;

  max_unpool_expand dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .count           (count),
    .Pool_BRAM_en    (Pool_BRAM_en),
    .Pool_BRAM_addr  (Pool_BRAM_addr),
    .Pool_read_data  (Pool_read_data),
    .Pool_read_index (Pool_read_index),
    .unpool_concat   (unpool_concat),
    .unpool_valid    (unpool_valid),
    .unpool_ready    (unpool_ready),
    .busy            (busy),
    .done            (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pooled BRAM, two-edge read latency: address captured at edge k, data valid at edge k+2.
  logic [15:0] mem_val [1024];
  logic        mem_idx [1024];
  logic [9:0]  bram_a1;

  always @(posedge clk) begin
    bram_a1         <= Pool_BRAM_addr;
    Pool_read_data  <= mem_val[bram_a1];
    Pool_read_index <= mem_idx[bram_a1];
  end

  // Downstream ready: held at 1, or a 50% coin toss each cycle.
  bit rnd_ready = 1'b0;
  initial begin
    unpool_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 unpool_ready = rnd_ready ? 1'($urandom % 2) : 1'b1;
    end
  end

  // Job bookkeeping, shared between the stimulus and the monitor.
  logic [31:0] exp_q [$];
  int          job_n;
  int          issued;
  int          xfers;
  int          n_done;
  int          first_en_cyc;
  int          first_valid_cyc;
  int          done_cyc;
  bit          stall_q = 1'b0;
  logic [31:0] stall_data;

  always @(negedge clk) begin
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (Pool_BRAM_en) begin
        if (first_en_cyc < 0) first_en_cyc = cyc;
        chk("rd_addr", 64'(Pool_BRAM_addr), 64'(issued));
        chk("rd_in_range", 64'(issued < job_n), 64'd1);
        issued++;
        chk("rd_credit", 64'((issued - xfers) <= 4), 64'd1);
      end
      if (stall_q) begin
        chk("hold_valid", 64'(unpool_valid), 64'd1);
        chk("hold_data", 64'(unpool_concat), 64'(stall_data));
      end
      if (unpool_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (unpool_valid && unpool_ready) begin
        chk("word_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) chk("word", 64'(unpool_concat), 64'(exp_q.pop_front()));
        xfers++;
      end
      stall_q    = unpool_valid && !unpool_ready;
      stall_data = unpool_concat;
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
    end
  end

  // Random fp16 patterns, with the special encodings that must pass through untouched.
  function automatic logic [15:0] rand_val();
    case ($urandom % 8)
      0:       return 16'h8000;
      1:       return 16'h7E00;
      2:       return 16'h7C00;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic launch(input int n, input bit build, output int c0);
    if (build) begin
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
        mem_val[i] = rand_val();
        mem_idx[i] = 1'($urandom % 2);
        exp_q.push_back(mem_idx[i] ? {mem_val[i], 16'h0000} : {16'h0000, mem_val[i]});
      end
    end
    job_n           = n;
    issued          = 0;
    xfers           = 0;
    n_done          = 0;
    first_en_cyc    = -1;
    first_valid_cyc = -1;
    done_cyc        = -1;
    count = 11'(n);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    c0    = cyc;
    count = 11'($urandom);
  endtask

  task automatic finish_job(input int n, input int c0, input bit timed);
    for (int k = 0; k < 4000 && n_done == 0; k++) begin
      @(posedge clk);
      #1;
    end
    chk("done_seen", 64'(n_done > 0), 64'd1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("done_once", 64'(n_done), 64'd1);
    chk("xfer_count", 64'(xfers), 64'(n));
    chk("read_count", 64'(issued), 64'(n));
    chk("words_left", 64'(exp_q.size()), 64'd0);
    chk("busy_after", 64'(busy), 64'd0);
    if (timed) begin
      if (n == 0) begin
        chk("done_time_n0", 64'(done_cyc), 64'(c0 + 1));
      end else begin
        chk("first_en_time", 64'(first_en_cyc), 64'(c0));
        chk("first_valid_time", 64'(first_valid_cyc), 64'(c0 + 3));
        chk("done_time", 64'(done_cyc), 64'(c0 + 3 + n));
      end
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_en"}, 64'(Pool_BRAM_en), 64'd0);
    chk({tag, "_addr"}, 64'(Pool_BRAM_addr), 64'd0);
    chk({tag, "_concat"}, 64'(unpool_concat), 64'd0);
    chk({tag, "_valid"}, 64'(unpool_valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    int c0;
    int n;

    rst   = 1'b1;
    start = 1'b0;
    count = '0;
    job_n = 0;
    for (int i = 0; i < 1024; i++) begin
      mem_val[i] = '0;
      mem_idx[i] = 1'b0;
    end

    // Reset with random inputs: outputs stay 0 and start has no effect.
    rnd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start = 1'($urandom % 2);
      count = 11'($urandom);
      @(posedge clk);
      #1;
      chk_idle_outputs("reset");
    end
    rst   = 1'b0;
    start = 1'b0;
    rnd_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset_busy", 64'(busy), 64'd0);
    chk("post_reset_valid", 64'(unpool_valid), 64'd0);

    // Basic expand with fixed data and literal expected words.
    mem_val[0] = 16'h3C00; mem_idx[0] = 1'b0;
    mem_val[1] = 16'h4000; mem_idx[1] = 1'b1;
    mem_val[2] = 16'hBC00; mem_idx[2] = 1'b1;
    mem_val[3] = 16'h7E00; mem_idx[3] = 1'b0;
    exp_q.delete();
    exp_q.push_back(32'h00003C00);
    exp_q.push_back(32'h40000000);
    exp_q.push_back(32'hBC000000);
    exp_q.push_back(32'h00007E00);
    launch(4, 1'b0, c0);
    finish_job(4, c0, 1'b1);

    // Back-pressure: N=16 with a 50% ready.
    rnd_ready = 1'b1;
    launch(16, 1'b1, c0);
    finish_job(16, c0, 1'b0);
    rnd_ready = 1'b0;
    @(posedge clk);
    #1;

    // Empty job: done only, two edges after start.
    exp_q.delete();
    launch(0, 1'b1, c0);
    finish_job(0, c0, 1'b1);

    // Full address space, last address all-ones.
    launch(1024, 1'b1, c0);
    finish_job(1024, c0, 1'b1);

    // Reset after the third transfer, then a start in the first cycle out of reset.
    launch(8, 1'b1, c0);
    for (int k = 0; k < 100 && xfers < 3; k++) begin
      @(posedge clk);
      #1;
    end
    chk("mid_reach3", 64'(xfers), 64'd3);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk_idle_outputs("mid_reset");
    rst = 1'b0;
    launch(2, 1'b1, c0);
    finish_job(2, c0, 1'b1);

    // A second start during a job is ignored.
    launch(3, 1'b1, c0);
    start = 1'b1;
    count = 11'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    finish_job(3, c0, 1'b1);

    // Random lengths under random back-pressure.
    rnd_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      n = $urandom_range(1, 40);
      launch(n, 1'b1, c0);
      finish_job(n, c0, 1'b0);
    end
    rnd_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
